// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter state encoding, bus width defaults and grant selection.
package wb_pkg;

   localparam int WB_AW      = 26;
   localparam int WB_DW      = 32;
   localparam int WB_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } arb_state_t;

   // Round-robin pick: on a tie the master that was not served last wins.
   function automatic arb_state_t pick_grant(input logic elig0,
                                             input logic elig1,
                                             input logic last);
      if (elig0 && elig1) begin
         return last ? GNT0 : GNT1;
      end
      if (elig0) begin
         return GNT0;
      end
      if (elig1) begin
         return GNT1;
      end
      return IDLE;
   endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Counts strobe cycles waiting for ACK; expire is a combinational one-cycle abort on the last allowed wait.
// ACK on the boundary cycle suppresses expire, so a late-but-legal slave completes normally.
module wb_watchdog
   import wb_pkg::*;
#(
   parameter int TIMEOUT = WB_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic ack,
   input  logic clr,
   output logic expire
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] wd_cnt;

   assign expire = run & ~ack & (wd_cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (clr || !run || ack) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter; grant held for a whole CYC, first STB one cycle after request.
// Slave stalls are bounded by the watchdog; an aborted master is locked out until it drops CYC.
module wb_arbiter_2m
   import wb_pkg::*;
#(
   parameter int AW      = WB_AW,
   parameter int DW      = WB_DW,
   parameter int TIMEOUT = WB_TIMEOUT
) (
   input  logic          clk_i,
   input  logic          rst_i,

   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   output logic [DW-1:0] m0_dat_o,
   input  logic          m0_we_i,
   input  logic          m0_stb_i,
   input  logic          m0_cyc_i,
   input  logic          m0_tagn_i,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   output logic          m0_gnt_o,

   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   output logic [DW-1:0] m1_dat_o,
   input  logic          m1_we_i,
   input  logic          m1_stb_i,
   input  logic          m1_cyc_i,
   input  logic          m1_tagn_i,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic          m1_gnt_o,

   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   input  logic [DW-1:0] s_dat_i,
   output logic          s_we_o,
   output logic          s_stb_o,
   output logic          s_cyc_o,
   output logic          s_tagn_o,
   input  logic          s_ack_i
);

   arb_state_t state;
   arb_state_t state_nxt;
   logic       last;
   logic       last_nxt;
   logic       lock0;
   logic       lock0_nxt;
   logic       lock1;
   logic       lock1_nxt;

   logic       sel0;
   logic       sel1;
   logic       elig0;
   logic       elig1;
   logic       wd_run;
   logic       wd_clr;
   logic       wd_expire;

   assign sel0   = (state == GNT0);
   assign sel1   = (state == GNT1);
   assign elig0  = m0_cyc_i & ~lock0;
   assign elig1  = m1_cyc_i & ~lock1;
   assign wd_run = (sel0 & m0_stb_i) | (sel1 & m1_stb_i);
   assign wd_clr = (state_nxt != state);

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk_i),
      .rst_n  (rst_i),
      .run    (wd_run),
      .ack    (s_ack_i),
      .clr    (wd_clr),
      .expire (wd_expire)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= IDLE;
         last  <= 1'b1;
         lock0 <= 1'b0;
         lock1 <= 1'b0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         lock0 <= lock0_nxt;
         lock1 <= lock1_nxt;
      end
   end

   // A released or aborted master is treated as ineligible so the grant moves on or goes idle.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      lock0_nxt = lock0;
      lock1_nxt = lock1;

      case (state)
         IDLE: begin
            state_nxt = pick_grant(elig0, elig1, last);
         end
         GNT0: begin
            if (!m0_cyc_i || wd_expire) begin
               last_nxt  = 1'b0;
               state_nxt = pick_grant(1'b0, elig1, 1'b0);
            end
         end
         GNT1: begin
            if (!m1_cyc_i || wd_expire) begin
               last_nxt  = 1'b1;
               state_nxt = pick_grant(elig0, 1'b0, 1'b1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (!m0_cyc_i) begin
         lock0_nxt = 1'b0;
      end else if (sel0 && wd_expire) begin
         lock0_nxt = 1'b1;
      end

      if (!m1_cyc_i) begin
         lock1_nxt = 1'b0;
      end else if (sel1 && wd_expire) begin
         lock1_nxt = 1'b1;
      end
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_we_o   = 1'b0;
      s_stb_o  = 1'b0;
      s_cyc_o  = 1'b0;
      s_tagn_o = 1'b0;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_gnt_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_gnt_o = 1'b0;

      case (state)
         GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_stb_o  = m0_stb_i & ~wd_expire;
            s_cyc_o  = m0_cyc_i & ~wd_expire;
            s_tagn_o = m0_tagn_i;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = wd_expire;
            m0_gnt_o = 1'b1;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_stb_o  = m1_stb_i & ~wd_expire;
            s_cyc_o  = m1_cyc_i & ~wd_expire;
            s_tagn_o = m1_tagn_i;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = wd_expire;
            m1_gnt_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus random two-master traffic against a
// delay-programmable slave; responses are scoreboarded per master.
module tb_wb_arbiter_2m;

   localparam int AW      = 26;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_i;
   logic [1:0]    m_cyc, m_stb, m_we;
   logic [AW-1:0] m_adr  [2];
   logic [DW-1:0] m_wdat [2];
   logic [DW-1:0] m0_rdat, m1_rdat;
   logic [1:0]    m_ack, m_err, m_gnt;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o, s_dat_i;
   logic          s_we_o, s_stb_o, s_cyc_o, s_tagn_o, s_ack_i;

   // Slave wait-state count for the master currently holding the bus (ack on strobe cycle dly+1).
   int dly [2];

   typedef struct {
      bit            err;
      bit            we;
      logic [DW-1:0] dat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_chk  = 0;
   int n_fail = 0;

   wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .m0_adr_i  (m_adr[0]),
      .m0_dat_i  (m_wdat[0]),
      .m0_dat_o  (m0_rdat),
      .m0_we_i   (m_we[0]),
      .m0_stb_i  (m_stb[0]),
      .m0_cyc_i  (m_cyc[0]),
      .m0_tagn_i (1'b0),
      .m0_ack_o  (m_ack[0]),
      .m0_err_o  (m_err[0]),
      .m0_gnt_o  (m_gnt[0]),
      .m1_adr_i  (m_adr[1]),
      .m1_dat_i  (m_wdat[1]),
      .m1_dat_o  (m1_rdat),
      .m1_we_i   (m_we[1]),
      .m1_stb_i  (m_stb[1]),
      .m1_cyc_i  (m_cyc[1]),
      .m1_tagn_i (1'b1),
      .m1_ack_o  (m_ack[1]),
      .m1_err_o  (m_err[1]),
      .m1_gnt_o  (m_gnt[1]),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_dat_i   (s_dat_i),
      .s_we_o    (s_we_o),
      .s_stb_o   (s_stb_o),
      .s_cyc_o   (s_cyc_o),
      .s_tagn_o  (s_tagn_o),
      .s_ack_i   (s_ack_i)
   );

   function automatic logic [DW-1:0] rdata_fn(input logic [AW-1:0] a);
      return 32'hDEADBEEF ^ {6'd0, a ^ 26'h10};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a strobe and record what the master must eventually see for it.
   task automatic issue(input bit id, input bit we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat, input int d);
      exp_t e;
      dly[id]    = d;
      m_adr[id]  = adr;
      m_wdat[id] = dat;
      m_we[id]   = we;
      m_cyc[id]  = 1'b1;
      m_stb[id]  = 1'b1;
      e.err = (d >= TIMEOUT);
      e.we  = we;
      e.dat = rdata_fn(adr);
      if (id == 1'b0) q0.push_back(e);
      else            q1.push_back(e);
   endtask

   task automatic wait_resp(input bit id, output int n, output bit got_err);
      n = 0;
      got_err = 1'b0;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         if (m_ack[id] || m_err[id]) begin
            n = k;
            got_err = m_err[id];
            break;
         end
      end
      if (n == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL resp_wait m%0d: no ack/err within 600 cycles", id);
      end
   endtask

   task automatic tie_round(input string tag);
      int n;
      bit e;
      issue(1'b0, 1'b0, AW'($urandom), '0, 2);
      issue(1'b1, 1'b0, AW'($urandom), '0, 2);
      tick();
      @(negedge clk);
      chk({tag, "_first_m0"}, m_gnt, 2'b01);
      wait_resp(1'b0, n, e);
      tick();
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      tick();
      @(negedge clk);
      chk({tag, "_handover_m1"}, m_gnt, 2'b10);
      wait_resp(1'b1, n, e);
      tick();
      m_cyc[1] = 1'b0;
      m_stb[1] = 1'b0;
      tick();
   endtask

   task automatic master_rand(input bit id, input int ncyc);
      int n, nstb, d, r;
      bit e, we;
      for (int c = 0; c < ncyc; c++) begin
         repeat ($urandom_range(0, 3)) tick();
         nstb = $urandom_range(1, 3);
         for (int s = 0; s < nstb; s++) begin
            r  = $urandom_range(0, 9);
            d  = (r < 7) ? $urandom_range(1, 5) : (r == 7) ? 15 : (r == 8) ? 16 : 24;
            we = 1'($urandom_range(0, 1));
            issue(id, we, AW'($urandom), $urandom, d);
            wait_resp(id, n, e);
            tick();
            m_stb[id] = 1'b0;
            if (e) break;
         end
         m_cyc[id] = 1'b0;
         tick();
      end
   endtask

   // Slave: checks the muxed request against the tagged master, acks after that master's delay.
   initial begin
      int   w;
      logic id;
      logic nack;
      logic [DW-1:0] ndat;
      w = 0;
      s_ack_i = 1'b0;
      s_dat_i = '0;
      forever begin
         @(negedge clk);
         nack = 1'b0;
         ndat = $urandom;
         if (s_cyc_o && s_stb_o) begin
            id = s_tagn_o;
            chk("slave_gnt_matches_tag", m_gnt[id], 1'b1);
            chk("slave_adr", s_adr_o, m_adr[id]);
            chk("slave_we", s_we_o, m_we[id]);
            if (s_we_o) chk("slave_wdat", s_dat_o, m_wdat[id]);
            if (s_ack_i) begin
               w = 0;
            end else begin
               w++;
               if (w == dly[id]) begin
                  nack = 1'b1;
                  ndat = rdata_fn(s_adr_o);
               end
            end
         end else begin
            w = 0;
         end
         @(posedge clk);
         #1;
         s_ack_i = nack;
         s_dat_i = ndat;
      end
   end

   // Monitor: every ack/err a master sees must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      bit   id;
      forever begin
         @(negedge clk);
         chk("single_grant", {1'b0, m_gnt == 2'b11}, 2'b00);
         for (int i = 0; i < 2; i++) begin
            id = i[0];
            if (m_ack[id] || m_err[id]) begin
               chk("resp_has_gnt", m_gnt[id], 1'b1);
               if ((id == 1'b0 ? q0.size() : q1.size()) == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL resp_unexpected m%0d: ack=%0b err=%0b with nothing outstanding",
                           id, m_ack[id], m_err[id]);
               end else begin
                  e = (id == 1'b0) ? q0.pop_front() : q1.pop_front();
                  chk("resp_kind", {m_ack[id], m_err[id]}, {~e.err, e.err});
                  if (!e.err && !e.we)
                     chk("resp_rdata", (id == 1'b0) ? m0_rdat : m1_rdat, e.dat);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      bit e;
      rst_i = 1'b0;
      m_cyc = '0;
      m_stb = '0;
      m_we  = '0;
      for (int i = 0; i < 2; i++) begin
         m_adr[i]  = '0;
         m_wdat[i] = '0;
         dly[i]    = 1;
      end
      repeat (3) tick();
      @(negedge clk);
      chk("reset_ctl", {s_cyc_o, s_stb_o, s_we_o, s_tagn_o, m_gnt, m_ack, m_err}, '0);
      chk("reset_sadr", s_adr_o, '0);
      chk("reset_sdat", s_dat_o, '0);
      chk("reset_mdat", {m0_rdat, m1_rdat}, '0);
      tick();
      rst_i = 1'b1;
      tick();

      // Single m0 read, three wait states
      issue(1'b0, 1'b0, 26'h000010, '0, 3);
      @(negedge clk);
      chk("t1_no_stb_in_req_cycle", s_stb_o, 1'b0);
      tick();
      @(negedge clk);
      chk("t1_stb_next_cycle", {s_stb_o, m_gnt}, 3'b101);
      wait_resp(1'b0, n, e);
      chk("t1_ack_cycle", n, 3);
      chk("t1_rdata", m0_rdat, 32'hDEADBEEF);
      chk("t1_m1_quiet", {m_ack[1], m1_rdat}, '0);
      tick();
      m_stb[0] = 1'b0;
      m_cyc[0] = 1'b0;
      tick();
      @(negedge clk);
      chk("t1_back_idle", {m_gnt, s_cyc_o}, 3'b000);

      // Simultaneous requests after reset, then alternation
      rst_i = 1'b0;
      repeat (2) tick();
      rst_i = 1'b1;
      tick();
      tie_round("t2a");
      tie_round("t2b");
      tie_round("t2c");

      // m1 write is not preempted by m0
      issue(1'b1, 1'b1, 26'h0000FF, 32'h12345678, 4);
      tick();
      @(negedge clk);
      chk("t3_m1_granted", m_gnt, 2'b10);
      tick();
      issue(1'b0, 1'b0, 26'h000020, '0, 2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_no_preempt", {m_gnt, s_adr_o, s_dat_o}, {2'b10, 26'h0000FF, 32'h12345678});
         tick();
      end
      wait_resp(1'b1, n, e);
      tick();
      m_stb[1] = 1'b0;
      @(negedge clk);
      chk("t3_hold_while_cyc", {m_gnt, s_stb_o}, 3'b100);
      tick();
      m_cyc[1] = 1'b0;
      tick();
      @(negedge clk);
      chk("t3_then_m0", m_gnt, 2'b01);
      wait_resp(1'b0, n, e);
      tick();
      m_stb[0] = 1'b0;
      m_cyc[0] = 1'b0;
      tick();

      // Slave never acks: abort on strobe cycle 16, m0 locked while CYC stays high
      issue(1'b0, 1'b0, 26'h000030, '0, 31);
      for (int k = 1; k <= 17; k++) begin
         tick();
         @(negedge clk);
         chk("t4_err_pulse", m_err[0], (k == TIMEOUT) ? 1'b1 : 1'b0);
         if (k == TIMEOUT) chk("t4_scyc_dropped", {s_cyc_o, s_stb_o}, 2'b00);
      end
      chk("t4_idle_after_abort", m_gnt, 2'b00);
      tick();
      issue(1'b1, 1'b0, 26'h000040, '0, 2);
      tick();
      @(negedge clk);
      chk("t4_m1_served", m_gnt, 2'b10);
      wait_resp(1'b1, n, e);
      tick();
      m_stb[1] = 1'b0;
      m_cyc[1] = 1'b0;
      tick();
      @(negedge clk);
      chk("t4_m0_locked", m_gnt, 2'b00);
      tick();
      m_stb[0] = 1'b0;
      m_cyc[0] = 1'b0;
      tick();
      issue(1'b0, 1'b0, 26'h000044, '0, 2);
      tick();
      @(negedge clk);
      chk("t4_lock_cleared", m_gnt, 2'b01);
      wait_resp(1'b0, n, e);
      tick();
      m_stb[0] = 1'b0;
      m_cyc[0] = 1'b0;
      tick();

      // Ack exactly on the watchdog boundary
      issue(1'b0, 1'b0, 26'h000050, '0, TIMEOUT - 1);
      wait_resp(1'b0, n, e);
      chk("t5_ack_cycle", n, TIMEOUT + 1);
      chk("t5_no_err", e, 1'b0);
      tick();
      m_stb[0] = 1'b0;
      m_cyc[0] = 1'b0;
      tick();

      // Reset in the middle of a read
      issue(1'b0, 1'b0, 26'h000060, '0, 10);
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      @(negedge clk);
      chk("t6_reset_ctl", {s_cyc_o, s_stb_o, s_we_o, s_tagn_o, m_gnt, m_ack, m_err}, '0);
      chk("t6_reset_data", {s_adr_o, s_dat_o}, '0);
      chk("t6_reset_mdat", {m0_rdat, m1_rdat}, '0);
      tick();
      m_stb[0] = 1'b0;
      m_cyc[0] = 1'b0;
      q0.delete();
      rst_i = 1'b1;
      tick();
      tie_round("t6");

      // Random concurrent traffic
      fork
         master_rand(1'b0, 25);
         master_rand(1'b1, 25);
      join
      repeat (5) tick();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
